dbg_mode_ctrl: RTL

- Debug-mode entry/exit controller; sits directly downstream of the hardware trigger unit and consumes its `breakpoint` output.
- Also accepts ebreak, external haltreq and single-step completion, and arbitrates them into one halt cause.
- Squashes the EX instruction, captures dpc/cause and drains the pipeline.
- Owns `dbg_mode`, which feeds back to the trigger unit and the CSR file, and sequences resume back to M-mode execution.

---
 rtl/dbg_mode_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/dbg_mode_ctrl.sv
// Debug-mode entry/exit controller.
// Arbitrates trigger, ebreak, haltreq and single-step into one halt cause, squashes EX,
// captures dpc/cause, drains the pipe, holds the core halted and sequences resume.
// Optional feature: define DBG_STEP_EN to enable dcsr.step single-stepping (cause 4).
module dbg_mode_ctrl #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DRAIN_MAX     = 16,
  parameter int unsigned RESUME_CYCLES = 2
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  breakpoint,
  input  logic                  ebreak_ex,
  input  logic                  dcsr_ebreakm,
  input  logic                  dcsr_step,
  input  logic                  haltreq,
  input  logic                  resumereq,
  input  logic                  ex_valid,
  input  logic                  retire_ex,
  input  logic [ADDR_WIDTH-1:0] pc_ex,
  input  logic [ADDR_WIDTH-1:0] next_pc_ex,
  input  logic                  pipe_idle,
  input  logic                  dpc_wr,
  input  logic [ADDR_WIDTH-1:0] dpc_wdata,
  output logic                  dbg_mode,
  output logic                  halted,
  output logic                  resumeack,
  output logic                  dbg_flush,
  output logic                  resume_redirect,
  output logic [ADDR_WIDTH-1:0] resume_pc,
  output logic [ADDR_WIDTH-1:0] dpc,
  output logic [2:0]            dcsr_cause,
  output logic                  drain_err
);

  // One counter serves both DRAIN (timeout) and RESUME (hold time).
  localparam int unsigned CntMax = (DRAIN_MAX > RESUME_CYCLES) ? DRAIN_MAX : RESUME_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] DrainLast  = CntW'(DRAIN_MAX - 1);
  localparam logic [CntW-1:0] ResumeLast = CntW'(RESUME_CYCLES - 1);

  localparam logic [2:0] CauseEbreak  = 3'd1;
  localparam logic [2:0] CauseTrigger = 3'd2;
  localparam logic [2:0] CauseHaltreq = 3'd3;
  localparam logic [2:0] CauseStep    = 3'd4;

  typedef enum logic [1:0] {StRun, StDrain, StHalted, StResume} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [ADDR_WIDTH-1:0] dpc_q;
  logic [2:0]            cause_q;
  logic                  drain_err_q;
  logic                  dbg_mode_q;
  logic                  halted_q;
  logic                  resumeack_q;
  logic                  redirect_q;

  logic                  step_hit;
  logic                  resume_go;
  logic                  evt;
  logic [2:0]            evt_cause;
  logic [ADDR_WIDTH-1:0] evt_pc;

  assign resume_go = (state_q == StHalted) && resumereq && !haltreq;

`ifdef DBG_STEP_EN
  logic step_armed_q;

  assign step_hit = step_armed_q && retire_ex;

  // Arm single-step on resume; disarm once the stepped instruction has halted us.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      step_armed_q <= 1'b0;
    end else if (resume_go) begin
      step_armed_q <= dcsr_step;
    end else if (evt && (evt_cause == CauseStep)) begin
      step_armed_q <= 1'b0;
    end
  end
`else
  logic unused_step;

  assign unused_step = ^{dcsr_step, retire_ex};
  assign step_hit    = 1'b0;
`endif

  // Prioritised halt-event arbitration; only meaningful while running.
  always_comb begin
    evt       = 1'b0;
    evt_cause = 3'd0;
    evt_pc    = '0;
    if (state_q == StRun) begin
      if (breakpoint) begin
        evt       = 1'b1;
        evt_cause = CauseTrigger;
        evt_pc    = pc_ex;
      end else if (ebreak_ex && ex_valid && dcsr_ebreakm) begin
        evt       = 1'b1;
        evt_cause = CauseEbreak;
        evt_pc    = pc_ex;
      end else if (haltreq && ex_valid) begin
        evt       = 1'b1;
        evt_cause = CauseHaltreq;
        evt_pc    = pc_ex;
      end else if (step_hit) begin
        // Stepped instruction retires, so resume at its successor.
        evt       = 1'b1;
        evt_cause = CauseStep;
        evt_pc    = next_pc_ex;
      end
    end
  end

  // Debug-mode FSM with registered status outputs.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      dpc_q       <= '0;
      cause_q     <= 3'd0;
      drain_err_q <= 1'b0;
      dbg_mode_q  <= 1'b0;
      halted_q    <= 1'b0;
      resumeack_q <= 1'b0;
      redirect_q  <= 1'b0;
    end else begin
      resumeack_q <= 1'b0;
      redirect_q  <= 1'b0;
      unique case (state_q)
        StRun: begin
          if (evt) begin
            state_q    <= StDrain;
            cnt_q      <= '0;
            dpc_q      <= evt_pc;
            cause_q    <= evt_cause;
            dbg_mode_q <= 1'b1;
          end
        end
        StDrain: begin
          if (pipe_idle || (cnt_q == DrainLast)) begin
            state_q  <= StHalted;
            halted_q <= 1'b1;
            cnt_q    <= '0;
            if (!pipe_idle) begin
              drain_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHalted: begin
          if (dpc_wr) begin
            dpc_q <= dpc_wdata;
          end
          if (resume_go) begin
            state_q    <= StResume;
            halted_q   <= 1'b0;
            redirect_q <= 1'b1;
            cnt_q      <= '0;
          end
        end
        StResume: begin
          if (cnt_q == ResumeLast) begin
            state_q     <= StRun;
            dbg_mode_q  <= 1'b0;
            resumeack_q <= 1'b1;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign dbg_flush       = cpu_rstn && evt;
  assign dbg_mode        = dbg_mode_q;
  assign halted          = halted_q;
  assign resumeack       = resumeack_q;
  assign resume_redirect = redirect_q;
  assign resume_pc       = dpc_q;
  assign dpc             = dpc_q;
  assign dcsr_cause      = cause_q;
  assign drain_err       = drain_err_q;

endmodule
